// File: rtl/except_ctrl_if.sv
// Signal bundle between the MEM stage / CP0 and except_ctrl.
// With TIMER_INT_EN defined the bundle also carries timer_int_i.
interface except_ctrl_if;
   logic        mem_valid_i;
   logic [31:0] mem_pc_i;
   logic        mem_in_delayslot_i;
   logic [31:0] mem_bad_addr_i;
   logic        adel_if_i;
   logic        ri_i;
   logic        syscall_i;
   logic        break_i;
   logic        ov_i;
   logic        adel_ld_i;
   logic        ades_i;
   logic        eret_i;
   logic [31:0] status_i;
   logic [31:0] cause_i;
   logic [31:0] epc_i;
   logic        bus_busy_i;
`ifdef TIMER_INT_EN
   logic        timer_int_i;
`endif
   logic        stall_req_o;
   logic        flush_o;
   logic [31:0] newpc_o;
   logic [31:0] excepttype_o;
   logic [31:0] current_inst_addr_o;
   logic        is_in_delayslot_o;
   logic [31:0] bad_addr_o;

   // Pipeline/CP0 side: drives the requests, observes the commit.
   modport master (
`ifdef TIMER_INT_EN
      output timer_int_i,
`endif
      output mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_bad_addr_i,
      output adel_if_i, ri_i, syscall_i, break_i, ov_i, adel_ld_i, ades_i, eret_i,
      output status_i, cause_i, epc_i, bus_busy_i,
      input  stall_req_o, flush_o, newpc_o, excepttype_o,
      input  current_inst_addr_o, is_in_delayslot_o, bad_addr_o
   );

   // Exception sequencer side.
   modport slave (
`ifdef TIMER_INT_EN
      input  timer_int_i,
`endif
      input  mem_valid_i, mem_pc_i, mem_in_delayslot_i, mem_bad_addr_i,
      input  adel_if_i, ri_i, syscall_i, break_i, ov_i, adel_ld_i, ades_i, eret_i,
      input  status_i, cause_i, epc_i, bus_busy_i,
      output stall_req_o, flush_o, newpc_o, excepttype_o,
      output current_inst_addr_o, is_in_delayslot_o, bad_addr_o
   );
endinterface

// File: rtl/except_ctrl.sv
// Exception/interrupt sequencer between MEM and CP0: prioritise, drain the data bus, commit once.
// Optional TIMER_INT_EN: timer_int_i is ORed into interrupt line IP7.
module except_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
   input logic           clk,
   input logic           rst,
   except_ctrl_if.slave  bus
);

   localparam int unsigned XLEN   = 32;
   localparam int unsigned CODE_W = 5;
   localparam int unsigned IP_W   = 8;

   localparam logic [CODE_W-1:0] CODE_INT   = CODE_W'(5'h01);
   localparam logic [CODE_W-1:0] CODE_ADEL  = CODE_W'(5'h04);
   localparam logic [CODE_W-1:0] CODE_ADES  = CODE_W'(5'h05);
   localparam logic [CODE_W-1:0] CODE_SYS   = CODE_W'(5'h08);
   localparam logic [CODE_W-1:0] CODE_BP    = CODE_W'(5'h09);
   localparam logic [CODE_W-1:0] CODE_RI    = CODE_W'(5'h0a);
   localparam logic [CODE_W-1:0] CODE_OV    = CODE_W'(5'h0c);
   localparam logic [CODE_W-1:0] CODE_ERET  = CODE_W'(5'h0e);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_COMMIT = 2'd2
   } state_e;

   typedef struct packed {
      logic [CODE_W-1:0] code;
      logic [XLEN-1:0]   pc;
      logic              dslot;
      logic [XLEN-1:0]   bad_addr;
      logic [XLEN-1:0]   target;
   } capture_t;

   state_e            state_q, state_d;
   capture_t          cap_q, cap_d;
   logic              flush_q, flush_d;
   logic [XLEN-1:0]   newpc_q, newpc_d;
   logic [XLEN-1:0]   excepttype_q, excepttype_d;
   logic [XLEN-1:0]   inst_addr_q, inst_addr_d;
   logic              dslot_q, dslot_d;
   logic [XLEN-1:0]   bad_addr_q, bad_addr_d;

   logic              stall_c;
   logic [IP_W-1:0]   ip_c;
   logic              int_pend_c;
   logic              any_flag_c;
   logic              hit_c;
   logic [CODE_W-1:0] code_c;
   logic [XLEN-1:0]   bad_c;
   logic              unused_c;

   // Pending interrupt lines, with the optional timer folded into IP7.
   always_comb begin
`ifdef TIMER_INT_EN
      ip_c = {bus.cause_i[15] | bus.timer_int_i, bus.cause_i[14:8]};
`else
      ip_c = bus.cause_i[15:8];
`endif
      int_pend_c = bus.status_i[0] & ~bus.status_i[1] & (|(ip_c & bus.status_i[15:8]));
   end

   assign any_flag_c = bus.adel_if_i | bus.ri_i | bus.syscall_i | bus.break_i |
                       bus.ov_i | bus.adel_ld_i | bus.ades_i | bus.eret_i;
   assign hit_c      = bus.mem_valid_i & (int_pend_c | any_flag_c);

   // Fixed-priority pick; an interrupt beats every synchronous flag.
   always_comb begin
      code_c = '0;
      bad_c  = '0;
      if (int_pend_c) begin
         code_c = CODE_INT;
      end else if (bus.adel_if_i) begin
         code_c = CODE_ADEL;
         bad_c  = bus.mem_pc_i;
      end else if (bus.ri_i) begin
         code_c = CODE_RI;
      end else if (bus.syscall_i) begin
         code_c = CODE_SYS;
      end else if (bus.break_i) begin
         code_c = CODE_BP;
      end else if (bus.ov_i) begin
         code_c = CODE_OV;
      end else if (bus.adel_ld_i) begin
         code_c = CODE_ADEL;
         bad_c  = bus.mem_bad_addr_i;
      end else if (bus.ades_i) begin
         code_c = CODE_ADES;
         bad_c  = bus.mem_bad_addr_i;
      end else if (bus.eret_i) begin
         code_c = CODE_ERET;
      end
   end

   // Next-state, capture and output logic.
   always_comb begin
      state_d      = state_q;
      cap_d        = cap_q;
      stall_c      = 1'b0;
      flush_d      = 1'b0;
      newpc_d      = '0;
      excepttype_d = '0;
      inst_addr_d  = '0;
      dslot_d      = 1'b0;
      bad_addr_d   = '0;

      case (state_q)
         S_IDLE: begin
            stall_c = hit_c;
            if (hit_c) begin
               cap_d.code     = code_c;
               cap_d.pc       = bus.mem_pc_i;
               cap_d.dslot    = bus.mem_in_delayslot_i;
               cap_d.bad_addr = bad_c;
               cap_d.target   = (code_c == CODE_ERET) ? bus.epc_i : EXC_VECTOR;
               state_d        = bus.bus_busy_i ? S_WAIT : S_COMMIT;
            end
         end
         S_WAIT: begin
            stall_c = 1'b1;
            if (!bus.bus_busy_i) begin
               state_d = S_COMMIT;
            end
         end
         S_COMMIT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Commit outputs are registered, so they are loaded on entry to COMMIT.
      if (state_d == S_COMMIT) begin
         flush_d      = 1'b1;
         newpc_d      = cap_d.target;
         excepttype_d = XLEN'(cap_d.code);
         inst_addr_d  = cap_d.pc;
         dslot_d      = cap_d.dslot;
         bad_addr_d   = cap_d.bad_addr;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cap_q        <= '0;
         flush_q      <= 1'b0;
         newpc_q      <= '0;
         excepttype_q <= '0;
         inst_addr_q  <= '0;
         dslot_q      <= 1'b0;
         bad_addr_q   <= '0;
      end else begin
         state_q      <= state_d;
         cap_q        <= cap_d;
         flush_q      <= flush_d;
         newpc_q      <= newpc_d;
         excepttype_q <= excepttype_d;
         inst_addr_q  <= inst_addr_d;
         dslot_q      <= dslot_d;
         bad_addr_q   <= bad_addr_d;
      end
   end

   assign bus.stall_req_o         = stall_c;
   assign bus.flush_o             = flush_q;
   assign bus.newpc_o             = newpc_q;
   assign bus.excepttype_o        = excepttype_q;
   assign bus.current_inst_addr_o = inst_addr_q;
   assign bus.is_in_delayslot_o   = dslot_q;
   assign bus.bad_addr_o          = bad_addr_q;

   // Status/Cause fields this block does not interpret.
   assign unused_c = ^{bus.status_i[31:16], bus.status_i[7:2],
                       bus.cause_i[31:16], bus.cause_i[7:0]};

endmodule

// File: tb/tb_except_ctrl.sv
// Self-checking bench for except_ctrl: directed cases plus random transactions vs. a reference model.
module tb_except_ctrl;

   typedef struct {
      logic        valid;
      logic [31:0] pc;
      logic        dslot;
      logic [31:0] bad;
      logic        adel_if, ri, sys, brk, ov, adel_ld, ades, eret;
      logic [31:0] status;
      logic [31:0] cause;
      logic [31:0] epc;
      logic        timer;
   } txn_t;

   localparam logic [31:0] VEC = 32'hBFC00380;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_cnt  = 0;
   int   total_cnt = 0;

   except_ctrl_if bus_if ();
   except_ctrl dut (.clk(clk), .rst(rst), .bus(bus_if));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   function automatic txn_t blank();
      txn_t t;
      t.valid = 1'b1; t.pc = '0; t.dslot = 1'b0; t.bad = '0;
      t.adel_if = 0; t.ri = 0; t.sys = 0; t.brk = 0; t.ov = 0;
      t.adel_ld = 0; t.ades = 0; t.eret = 0;
      t.status = 32'h0000_0002; t.cause = '0; t.epc = '0; t.timer = 1'b0;
      return t;
   endfunction

   function automatic txn_t rnd_txn();
      txn_t t;
      t.valid   = ($urandom_range(0, 7) != 0);
      t.pc      = $urandom;
      t.dslot   = 1'($urandom_range(0, 1));
      t.bad     = $urandom;
      t.adel_if = ($urandom_range(0, 9) == 0);
      t.ri      = ($urandom_range(0, 9) == 0);
      t.sys     = ($urandom_range(0, 9) == 0);
      t.brk     = ($urandom_range(0, 9) == 0);
      t.ov      = ($urandom_range(0, 9) == 0);
      t.adel_ld = ($urandom_range(0, 9) == 0);
      t.ades    = ($urandom_range(0, 9) == 0);
      t.eret    = ($urandom_range(0, 9) == 0);
      t.status  = $urandom;
      t.cause   = $urandom & 32'hFFFF_00FF;
      if ($urandom_range(0, 1) == 1) t.cause[8 + $urandom_range(0, 7)] = 1'b1;
      t.epc     = $urandom;
      t.timer   = ($urandom_range(0, 3) == 0);
      return t;
   endfunction

   // Reference: first raised cause in priority order decides code, bad address and target.
   function automatic void model(input txn_t t, output logic hit, output logic [31:0] code,
                                 output logic [31:0] bad, output logic [31:0] tgt);
      int          codes [9] = '{1, 4, 10, 8, 9, 12, 4, 5, 14};
      logic [8:0]  req;
      logic [7:0]  lines;
      logic        ipend;
      lines = t.cause[15:8];
`ifdef TIMER_INT_EN
      lines[7] = lines[7] | t.timer;
`endif
      ipend = t.status[0] && !t.status[1] && ((lines & t.status[15:8]) != 8'd0);
      req   = {t.eret, t.ades, t.adel_ld, t.ov, t.brk, t.sys, t.ri, t.adel_if, ipend};
      hit   = t.valid && (req != 9'd0);
      code  = '0;
      bad   = '0;
      for (int i = 0; i < 9; i++) begin
         if (req[i]) begin
            code = 32'(codes[i]);
            if (i == 1) bad = t.pc;
            else if (i == 6 || i == 7) bad = t.bad;
            break;
         end
      end
      tgt = (code == 32'd14) ? t.epc : VEC;
   endfunction

   task automatic drive(input txn_t t);
      bus_if.mem_valid_i        = t.valid;
      bus_if.mem_pc_i           = t.pc;
      bus_if.mem_in_delayslot_i = t.dslot;
      bus_if.mem_bad_addr_i     = t.bad;
      bus_if.adel_if_i          = t.adel_if;
      bus_if.ri_i               = t.ri;
      bus_if.syscall_i          = t.sys;
      bus_if.break_i            = t.brk;
      bus_if.ov_i               = t.ov;
      bus_if.adel_ld_i          = t.adel_ld;
      bus_if.ades_i             = t.ades;
      bus_if.eret_i             = t.eret;
      bus_if.status_i           = t.status;
      bus_if.cause_i            = t.cause;
      bus_if.epc_i              = t.epc;
`ifdef TIMER_INT_EN
      bus_if.timer_int_i        = t.timer;
`endif
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_flush"}, 32'(bus_if.flush_o), 32'd0);
      chk({tag, "_exc"}, bus_if.excepttype_o, 32'd0);
      chk({tag, "_newpc"}, bus_if.newpc_o, 32'd0);
      chk({tag, "_badaddr"}, bus_if.bad_addr_o, 32'd0);
      chk({tag, "_instaddr"}, bus_if.current_inst_addr_o, 32'd0);
      chk({tag, "_dslot"}, 32'(bus_if.is_in_delayslot_o), 32'd0);
   endtask

   // One instruction in MEM with n busy bus cycles; called ~1 time unit after a rising edge.
   task automatic run_txn(input string tag, input txn_t t, input int n);
      logic        hit;
      logic [31:0] code, bad, tgt;
      txn_t        g;
      model(t, hit, code, bad, tgt);
      drive(t);
      bus_if.bus_busy_i = (n > 0);
      #1;
      chk({tag, "_stall0"}, 32'(bus_if.stall_req_o), 32'(hit));
      if (!hit) begin
         @(posedge clk); #1;
         bus_if.bus_busy_i = 1'b0;
         chk_quiet({tag, "_nohit"});
         return;
      end
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         g = rnd_txn();
         g.valid = 1'b1;
         drive(g);
         bus_if.bus_busy_i = (k < n);
         chk({tag, "_wstall"}, 32'(bus_if.stall_req_o), 32'd1);
         chk({tag, "_wflush"}, 32'(bus_if.flush_o), 32'd0);
         chk({tag, "_wexc"}, bus_if.excepttype_o, 32'd0);
      end
      @(posedge clk); #1;
      g = blank();
      g.valid = 1'b0;
      drive(g);
      bus_if.bus_busy_i = 1'($urandom_range(0, 1));
      chk({tag, "_flush"}, 32'(bus_if.flush_o), 32'd1);
      chk({tag, "_exc"}, bus_if.excepttype_o, code);
      chk({tag, "_newpc"}, bus_if.newpc_o, tgt);
      chk({tag, "_instaddr"}, bus_if.current_inst_addr_o, t.pc);
      chk({tag, "_dslot"}, 32'(bus_if.is_in_delayslot_o), 32'(t.dslot));
      chk({tag, "_badaddr"}, bus_if.bad_addr_o, bad);
      chk({tag, "_cstall"}, 32'(bus_if.stall_req_o), 32'd0);
      @(posedge clk); #1;
      bus_if.bus_busy_i = 1'b0;
      chk_quiet({tag, "_after"});
      chk({tag, "_astall"}, 32'(bus_if.stall_req_o), 32'd0);
   endtask

   initial begin
      txn_t t;
      t = blank();
      t.valid = 1'b0;
      drive(t);
      bus_if.bus_busy_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk_quiet("reset");
      chk("reset_stall", 32'(bus_if.stall_req_o), 32'd0);

      // syscall, bus idle
      t = blank(); t.sys = 1; t.pc = 32'hBFC00100;
      run_txn("syscall", t, 0);

      // ades with three busy cycles
      t = blank(); t.ades = 1; t.bad = 32'h80001002; t.pc = 32'hBFC00110;
      run_txn("ades_busy", t, 3);

      // interrupt beats ov, then EXL masks it
      t = blank(); t.ov = 1; t.status = 32'h0000_0401; t.cause = 32'h0000_0400; t.pc = 32'hBFC00120;
      run_txn("int_vs_ov", t, 0);
      t.status = 32'h0000_0403;
      run_txn("ov_exl", t, 1);

      // eret returns to EPC
      t = blank(); t.eret = 1; t.epc = 32'hBFC00204; t.pc = 32'hBFC00130;
      run_txn("eret", t, 0);

      // fetch address error beats load error, delay slot reported
      t = blank(); t.adel_if = 1; t.adel_ld = 1; t.pc = 32'hBFC00102; t.bad = 32'h12345678; t.dslot = 1;
      run_txn("adel_if", t, 2);

      // reset while waiting for the bus
      t = blank(); t.brk = 1; t.pc = 32'hBFC00140;
      drive(t);
      bus_if.bus_busy_i = 1'b1;
      @(posedge clk); #1;
      t.valid = 1'b0;
      drive(t);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_quiet("rst_wait");
      chk("rst_wait_stall", 32'(bus_if.stall_req_o), 32'd0);
      bus_if.bus_busy_i = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("rst_nocommit_flush", 32'(bus_if.flush_o), 32'd0);
         chk("rst_nocommit_exc", bus_if.excepttype_o, 32'd0);
      end

      // random transactions
      for (int i = 0; i < 300; i++) begin
         run_txn("rand", rnd_txn(), int'($urandom_range(0, 4)));
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- Exception/interrupt sequencer between the MEM stage and CP0.
- Collects per-instruction exception flags and pending interrupts, then picks the highest priority.
- Holds the pipeline until any outstanding data-bus transaction drains.
- Then issues a one-cycle commit: CP0 `excepttype`/EPC/BadVAddr update, pipeline flush and redirect PC (exception vector or EPC for `eret`).

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect PC for every exception except `eret`.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- mem_valid_i  in  1  valid instruction in MEM
- mem_pc_i  in  32  PC of MEM instruction
- mem_in_delayslot_i  in  1  MEM instruction in delay slot
- mem_bad_addr_i  in  32  data address of load/store
- adel_if_i, ri_i, syscall_i, break_i, ov_i, adel_ld_i, ades_i, eret_i  in  1 each  exception flags of MEM instruction
- status_i  in  32  CP0 Status
- cause_i  in  32  CP0 Cause
- epc_i  in  32  CP0 EPC
- bus_busy_i  in  1  data-bus transaction outstanding
- stall_req_o  out  1  freeze IF..MEM
- flush_o  out  1  flush all stages
- newpc_o  out  32  redirect target, valid when flush_o=1
- excepttype_o  out  32  to CP0; nonzero for exactly one cycle per commit
- current_inst_addr_o  out  32  to CP0
- is_in_delayslot_o  out  1  to CP0
- bad_addr_o  out  32  to CP0

Behaviour:
- Interrupt pending (int_pend) = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]).
- hit = mem_valid_i & (int_pend | any flag).
- Priority and codes, highest first:
  - int 0x1
  - adel_if 0x4 (bad addr = mem_pc_i)
  - ri 0xa
  - syscall 0x8
  - break 0x9
  - ov 0xc
  - adel_ld 0x4 (bad addr = mem_bad_addr_i)
  - ades 0x5 (bad addr = mem_bad_addr_i)
  - eret 0xe
- FSM states IDLE, WAIT, COMMIT; 2-bit state register.
- IDLE:
  - stall_req_o = hit (combinational).
  - On hit: capture code, pc, delayslot, bad addr and target (epc_i if code 0xe, else EXC_VECTOR).
  - Next state is WAIT if bus_busy_i, else COMMIT.
- WAIT:
  - stall_req_o = 1; inputs ignored.
  - Move to COMMIT in the cycle after bus_busy_i is sampled 0.
- COMMIT, one cycle:
  - flush_o = 1, excepttype_o = captured code, newpc_o = captured target, CP0 fields driven from captures.
  - stall_req_o = 0; next state IDLE.
- Outside COMMIT: excepttype_o = 0, flush_o = 0, newpc_o = 0, and the CP0 outputs are 0.
- Latency: hit with bus idle gives commit in the next cycle; each extra busy cycle adds one cycle.
- New hits are ignored in WAIT/COMMIT. The captured values are not overwritten.
- Simultaneous interrupt and synchronous flag: interrupt wins, and the instruction is re-executed after return.
- No re-trigger: in the IDLE cycle after COMMIT, mem_valid_i is 0 (flushed) and CP0 has EXL=1.
- Reset at any point, including in WAIT: state goes to IDLE and all outputs and captures become 0 on the next edge.

Optional Feature:
TIMER_INT_EN:
- Defined: adds input timer_int_i (1 bit). int_pend uses cause IP7 as (cause_i[15] | timer_int_i), masked by status_i[15].
- Undefined: the port is absent and int_pend uses cause_i[15] only.

Test Plan:
- syscall_i=1, mem_pc_i=32'hBFC00100, bus idle → next cycle: excepttype_o=0x8, flush_o=1, newpc_o=32'hBFC00380, current_inst_addr_o=32'hBFC00100, all for one cycle only.
- ades_i=1, mem_bad_addr_i=32'h80001002, bus_busy_i high for 3 cycles → stall_req_o=1 for 4 cycles, then excepttype_o=0x5, bad_addr_o=32'h80001002.
- status_i=32'h0000_0401, cause_i=32'h0000_0400, ov_i=1 → excepttype_o=0x1 (interrupt beats ov); with status_i[1]=1 → excepttype_o=0xc.
- eret_i=1, epc_i=32'hBFC00204 → excepttype_o=0xe, newpc_o=32'hBFC00204.
- adel_if_i=1 and adel_ld_i=1, mem_pc_i=32'hBFC00102 → excepttype_o=0x4, bad_addr_o=32'hBFC00102; mem_in_delayslot_i=1 is reflected on is_in_delayslot_o.
- rst pulse during WAIT → outputs 0 and state IDLE next cycle; no commit follows after bus_busy_i drops.
